sprite_cmd_queue: RTL and testbench
===================================

# sprite_cmd_queue

Avalon-MM slave that accepts 32-bit sprite command words from software, buffers them in a FIFO, and issues them one per cycle on the broadcast command bus that feeds every sprite display module (Mush_display and its siblings). Flush commands (buffer swap) are held until vertical blank, so swaps never tear the visible frame. Every cycle without a command carries a NOP, so each downstream module acts on each word exactly once.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥ 4.
- VACTIVE, 480: first vcount value of vertical blank.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high.
- chipselect  input  1  Avalon slave select.
- write  input  1  Avalon write strobe.
- read  input  1  Avalon read strobe (used only with CMD_STATUS_EN).
- address  input  1  0 = command push, 1 = status.
- writedata  input  32  command word; fields [31:26] component, [25:21] sprite, [20:17] command, [16:14] type, [13] buffer select, [12:0] data.
- readdata  output  32  status word; 0 without CMD_STATUS_EN.
- waitrequest  output  1  high while FIFO full.
- vcount  input  10  current scan line from the VGA counter.
- cmd_out  output  32  broadcast command word to all sprite display modules.

## Operation
- Push: chipselect & write & address==0 & !waitrequest stores writedata at FIFO tail. Writes to address 1 ignored.
- Flush word: command field == 4'b1111. All other command values forwarded unchanged, including unknown ones.
- vblank = (vcount ≥ VACTIVE).
- Issue FSM, states ISSUE, HOLD:
  - ISSUE: FIFO empty → cmd_out = NOP (32'h0). Head non-flush → pop, cmd_out = head next cycle. Head flush and vblank and !swapped → pop, cmd_out = head, set swapped. Head flush otherwise → go to HOLD, cmd_out = NOP.
  - HOLD: cmd_out = NOP; leave to ISSUE (issuing the flush) on the first cycle with vblank & !swapped.
- swapped: set when a flush is issued; cleared on any cycle with !vblank. At most one flush per vertical blank; a second flush waits for the next vblank, blocking all words behind it (strict order).
- Full: waitrequest = (count == DEPTH), registered-equivalent from count only; a pop in the same cycle does not lower it.
- Empty with simultaneous push: word not issued in the push cycle; follows normal latency.
- Reset (any time, including mid-HOLD): FIFO emptied, count 0, state ISSUE, swapped 0, cmd_out = 32'h0, waitrequest 0, readdata 0. In-flight writes in the reset cycle discarded.

## Timing
- cmd_out registered. Push accepted at edge k into empty FIFO, non-flush → cmd_out = word from edge k+2 for exactly one cycle, then NOP (or next word).
- Back-to-back non-flush words issue on consecutive cycles; throughput 1 word/cycle.
- Flush at head during vblank, !swapped: same 2-edge latency as other words.
- vcount sampled combinationally each cycle; no synchroniser (same clock domain).

## Configuration
- CMD_STATUS_EN defined: read & chipselect & address==1 returns readdata = {22'b0, hold, swapped, count[7:0]} registered, valid one cycle after the read strobe; waitrequest unaffected by reads.
- Undefined: read ignored, readdata tied to 0, no status logic synthesised.

## Structure
- Package sprite_cmd_pkg: field-position localparams (COMP_MSB..DATA_LSB), CMD_FLUSH = 4'b1111, CMD_NOP_WORD = 32'h0, issue-state enum {ISSUE, HOLD}. Shared with display modules' decode.
- Sub-module cmd_fifo: synchronous FIFO (push, pop, data in/out, count, full, empty), DEPTH parameter, pointer wrap via power-of-two width.

## Test plan
- Reset, then push 32'h24220005 at vcount 100 → cmd_out = 32'h24220005 two edges later for one cycle, then 32'h0.
- Push 16 words with no pop possible (flush at head, vcount 100) → waitrequest high after 16th accepted; 17th held until a pop.
- Push flush 32'h001E2000 at vcount 200 → cmd_out stays 0 until vcount 480, then issues flush once.
- Push two flushes during vblank → first issued at once; second held until vcount returns < 480 and then ≥ 480.
- Push flush then 32'h24220005 at vcount 300 → data word not issued before flush; order preserved.
- Assert reset during HOLD with 5 entries → cmd_out 0, count 0, waitrequest 0; later flush issues normally (with CMD_STATUS_EN, status read returns count 0).

Source files
------------

// File: rtl/sprite_cmd_pkg.sv
// sprite_cmd_pkg: shared definitions for the sprite command bus.
// Holds the command-word field positions, the flush opcode, the NOP word and the
// issue-state enum. Display modules import this package to decode cmd_out.
// No ports (package).

package sprite_cmd_pkg;

   // Command word field positions
   localparam int unsigned COMP_MSB = 31;
   localparam int unsigned COMP_LSB = 26;
   localparam int unsigned SPR_MSB  = 25;
   localparam int unsigned SPR_LSB  = 21;
   localparam int unsigned CMD_MSB  = 20;
   localparam int unsigned CMD_LSB  = 17;
   localparam int unsigned TYPE_MSB = 16;
   localparam int unsigned TYPE_LSB = 14;
   localparam int unsigned BUF_BIT  = 13;
   localparam int unsigned DATA_MSB = 12;
   localparam int unsigned DATA_LSB = 0;

   localparam logic [3:0]  CMD_FLUSH    = 4'b1111;
   localparam logic [31:0] CMD_NOP_WORD = 32'h0;

   typedef enum logic [0:0] {ISSUE, HOLD} issue_state_e;

   // True when the word is a buffer-swap (flush) command
   function automatic logic is_flush(input logic [31:0] word);
      return word[CMD_MSB:CMD_LSB] == CMD_FLUSH;
   endfunction

   // Assemble a command word from its fields
   function automatic logic [31:0] pack_cmd(input logic [5:0]  comp,
                                            input logic [4:0]  sprite,
                                            input logic [3:0]  cmd,
                                            input logic [2:0]  typ,
                                            input logic        buf_sel,
                                            input logic [12:0] data);
      logic [31:0] word;
      word                    = CMD_NOP_WORD;
      word[COMP_MSB:COMP_LSB] = comp;
      word[SPR_MSB:SPR_LSB]   = sprite;
      word[CMD_MSB:CMD_LSB]   = cmd;
      word[TYPE_MSB:TYPE_LSB] = typ;
      word[BUF_BIT]           = buf_sel;
      word[DATA_MSB:DATA_LSB] = data;
      return word;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous single-clock FIFO with power-of-two depth.
// Ports:
//   clk, reset     clock, synchronous active-high reset (empties the FIFO)
//   push, din      write request and data (ignored when full)
//   pop, dout      read request (ignored when empty); dout shows the head word
//   count          number of stored entries (0..DEPTH)
//   full, empty    status flags derived from count

module cmd_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_COUNT);
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr_q];
   assign count   = count_q;

   // Storage has no reset; pointers and count define validity
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= din;
      end
   end

   // Pointers wrap naturally at the power-of-two width
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sprite_cmd_queue.sv
// sprite_cmd_queue: Avalon-MM slave buffering sprite command words and broadcasting
// them one per cycle on cmd_out. Flush (buffer swap) words wait for vertical blank,
// with at most one flush per blank; words behind a held flush wait too.
// Optional feature macro: CMD_STATUS_EN (status register readable at address 1).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   chipselect, write,    Avalon slave strobes; address 0 pushes writedata,
//   read, address         address 1 reads status (CMD_STATUS_EN only)
//   writedata             command word to enqueue
//   readdata              {22'b0, hold, swapped, count[7:0]} or 0 when status disabled
//   waitrequest           high while the FIFO is full
//   vcount                current scan line
//   cmd_out               registered broadcast command word (NOP when idle)

module sprite_cmd_queue #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned VACTIVE = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic        address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        waitrequest,
   input  logic [9:0]  vcount,
   output logic [31:0] cmd_out
);

   import sprite_cmd_pkg::*;

   localparam int unsigned AW          = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT  = DEPTH[AW:0];
   localparam logic [9:0]  VBLANK_LINE = VACTIVE[9:0];

   issue_state_e state_q, state_d;
   logic         swapped_q, swapped_d;
   logic [31:0]  issue_q, issue_d;
   logic [31:0]  cmd_q;

   logic         fifo_push, fifo_pop;
   logic [31:0]  head;
   logic [AW:0]  fifo_count;
   logic         fifo_full, fifo_empty;
   logic         vblank, head_flush, flush_ok, issue_flush;

   // Full is taken from the registered count so a same-cycle pop never lowers it
   assign waitrequest = (fifo_count == FULL_COUNT);
   assign fifo_push   = chipselect & write & ~address & ~waitrequest;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (writedata),
      .pop   (fifo_pop),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign vblank     = (vcount >= VBLANK_LINE);
   assign head_flush = is_flush(head);
   assign flush_ok   = vblank & ~swapped_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ISSUE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ISSUE:   if (!fifo_empty && head_flush && !flush_ok) state_d = HOLD;
         HOLD:    if (flush_ok) state_d = ISSUE;
         default: state_d = ISSUE;
      endcase
   end

   // Output logic: pop decision and the word entering the issue pipeline
   always_comb begin
      fifo_pop    = 1'b0;
      issue_flush = 1'b0;
      unique case (state_q)
         ISSUE: begin
            if (!fifo_empty) begin
               if (!head_flush) begin
                  fifo_pop = 1'b1;
               end else if (flush_ok) begin
                  fifo_pop    = 1'b1;
                  issue_flush = 1'b1;
               end
            end
         end
         HOLD: begin
            if (flush_ok && !fifo_empty) begin
               fifo_pop    = 1'b1;
               issue_flush = 1'b1;
            end
         end
         default: ;
      endcase
      issue_d = fifo_pop ? head : CMD_NOP_WORD;
   end

   // A flush is only ever issued inside vblank, so set and clear cannot collide
   always_comb begin
      swapped_d = swapped_q;
      if (issue_flush) begin
         swapped_d = 1'b1;
      end else if (!vblank) begin
         swapped_d = 1'b0;
      end
   end

   // Two-stage issue pipeline: popped word, then the broadcast register
   always_ff @(posedge clk) begin
      if (reset) begin
         swapped_q <= 1'b0;
         issue_q   <= CMD_NOP_WORD;
         cmd_q     <= CMD_NOP_WORD;
      end else begin
         swapped_q <= swapped_d;
         issue_q   <= issue_d;
         cmd_q     <= issue_q;
      end
   end

   assign cmd_out = cmd_q;

`ifdef CMD_STATUS_EN
   logic [31:0] status_q;
   logic [7:0]  count8;
   logic        unused_sig;

   assign count8     = 8'(fifo_count);
   assign unused_sig = fifo_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         status_q <= '0;
      end else if (chipselect && read && address) begin
         status_q <= {22'b0, (state_q == HOLD), swapped_q, count8};
      end
   end

   assign readdata = status_q;
`else
   logic unused_sig;
   assign unused_sig = ^{fifo_full, read};
   assign readdata   = '0;
`endif

endmodule

// File: tb/tb_sprite_cmd_queue.sv
module tb_sprite_cmd_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect, write, read, address;
   logic [31:0] writedata, readdata, cmd_out;
   logic        waitrequest;
   logic [9:0]  vcount;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];

   localparam logic [31:0] DATA_W = 32'h24220005;

   always #5 clk = ~clk;

   sprite_cmd_queue #(
      .DEPTH   (16),
      .VACTIVE (480)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .chipselect  (chipselect),
      .write       (write),
      .read        (read),
      .address     (address),
      .writedata   (writedata),
      .readdata    (readdata),
      .waitrequest (waitrequest),
      .vcount      (vcount),
      .cmd_out     (cmd_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every non-NOP word on the bus must be the next expected one
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && cmd_out !== 32'h0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %h expected no word", cmd_out);
            end else begin
               check("cmd_order", cmd_out, exp_q.pop_front());
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic push(input logic [31:0] w, input bit expect_out);
      int n = 0;
      chipselect = 1'b1;
      write      = 1'b1;
      address    = 1'b0;
      writedata  = w;
      while (waitrequest !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: got waitrequest %b expected 0", waitrequest);
      end
      if (expect_out) exp_q.push_back(w);
      @(negedge clk);
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic status_read(output logic [31:0] val);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = 1'b1;
      @(negedge clk);
      chipselect = 1'b0;
      read       = 1'b0;
      address    = 1'b0;
      val        = readdata;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] st;
      logic [31:0] exp_st;
      reset      = 1'b1;
      chipselect = 1'b0;
      write      = 1'b0;
      read       = 1'b0;
      address    = 1'b0;
      writedata  = '0;
      vcount     = 10'd100;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_cmd_out", cmd_out, 32'h0);
      check("rst_waitrequest", 32'(waitrequest), 32'd0);
      check("rst_readdata", readdata, 32'h0);

      // Single data word: visible from the second edge after acceptance, one cycle
      push(DATA_W, 1'b1);
      check("lat_edge0", cmd_out, 32'h0);
      @(negedge clk);
      check("lat_edge1", cmd_out, 32'h0);
      @(negedge clk);
      check("lat_edge2", cmd_out, DATA_W);
      @(negedge clk);
      check("lat_after", cmd_out, 32'h0);
      drain("t1_drain");

      // Fill: flush held at head outside vblank blocks all pops
      push(32'h001E2000, 1'b1);
      for (int i = 1; i <= 15; i++) push(32'h24220000 | i, 1'b1);
      check("full_wait", 32'(waitrequest), 32'd1);
      status_read(st);
`ifdef CMD_STATUS_EN
      exp_st = 32'h0000_0210;
`else
      exp_st = 32'h0;
`endif
      check("full_status", st, exp_st);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = 1'b0;
      writedata  = 32'h24220010;
      repeat (3) begin
         @(negedge clk);
         check("full_held", 32'(waitrequest), 32'd1);
         check("full_nop", cmd_out, 32'h0);
      end
      exp_q.push_back(32'h24220010);
      vcount = 10'd480;
      begin
         int n = 0;
         while (waitrequest !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("full_release", 32'(waitrequest), 32'd0);
      end
      @(negedge clk);
      chipselect = 1'b0;
      write      = 1'b0;
      drain("full_drain");

      // Flush pushed mid-frame waits for line 480
      vcount = 10'd200;
      repeat (2) @(negedge clk);
      push(32'h001E2000, 1'b1);
      repeat (6) begin
         @(negedge clk);
         check("hold_nop", cmd_out, 32'h0);
      end
      vcount = 10'd480;
      drain("hold_drain");

      // Two flushes in one vblank: second waits for the next vblank
      vcount = 10'd100;
      repeat (2) @(negedge clk);
      vcount = 10'd480;
      push(32'h001E2001, 1'b1);
      push(32'h001E2002, 1'b1);
      repeat (10) @(negedge clk);
      check("two_flush_held", 32'(exp_q.size()), 32'd1);
      vcount = 10'd100;
      repeat (3) @(negedge clk);
      check("two_flush_active", 32'(exp_q.size()), 32'd1);
      vcount = 10'd480;
      drain("two_flush_drain");

      // Order: data behind a held flush stays behind it
      vcount = 10'd100;
      repeat (2) @(negedge clk);
      vcount = 10'd300;
      push(32'h001E2004, 1'b1);
      push(DATA_W, 1'b1);
      repeat (5) begin
         @(negedge clk);
         check("order_nop", cmd_out, 32'h0);
      end
      vcount = 10'd480;
      drain("order_drain");

      // Reset while holding five entries; write in the reset cycle is dropped
      vcount = 10'd100;
      repeat (2) @(negedge clk);
      push(32'h001E2005, 1'b0);
      for (int i = 1; i <= 4; i++) push(32'h24220020 | i, 1'b0);
      repeat (3) @(negedge clk);
      reset      = 1'b1;
      chipselect = 1'b1;
      write      = 1'b1;
      address    = 1'b0;
      writedata  = 32'h11111111;
      @(negedge clk);
      reset      = 1'b0;
      chipselect = 1'b0;
      write      = 1'b0;
      check("mid_rst_cmd_out", cmd_out, 32'h0);
      check("mid_rst_wait", 32'(waitrequest), 32'd0);
      status_read(st);
      check("mid_rst_status", st, 32'h0);
      repeat (5) @(negedge clk);
      vcount = 10'd480;
      push(32'h001E2006, 1'b1);
      drain("post_rst_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
